// File: rtl/pkt_fifo_param.sv
// rtl/pkt_fifo_param.sv - parametrised packet-aware synchronous FIFO with SOP/EOP tracking and sticky error flags
module pkt_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int LEN_LSB   = 2,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       soft_rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic                       lfd_state,
    input  logic [DATA_W-1:0]          din,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic                       sop_out,
    output logic                       eop_out,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       pkt_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = DATA_W - LEN_LSB;
    localparam int RW = LW + 1;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_L    = (AW+1)'(AE_THRESH);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_t;

    // Bit DATA_W of each entry carries the header tag written with the word.
    logic [DATA_W:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [RW-1:0]    pkt_rem;
    logic [RW-1:0]    pkt_rem_n;
    pkt_state_t       state;
    pkt_state_t       state_n;
    logic             wr_acc;
    logic             rd_acc;
    logic [DATA_W:0]  rd_word;
    logic [LW-1:0]    rd_len;
    logic             sop_n;
    logic             eop_n;
    logic             err_n;

    assign full         = (level == DEPTH_L);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    assign wr_acc  = wr_en & ~full;
    assign rd_acc  = rd_en & ~empty;
    assign rd_word = mem[rd_ptr];
    assign rd_len  = rd_word[DATA_W-1:LEN_LSB];

    // Packet tracking on the word leaving the FIFO this cycle.
    always_comb begin
        state_n   = state;
        pkt_rem_n = pkt_rem;
        sop_n     = 1'b0;
        eop_n     = 1'b0;
        err_n     = 1'b0;
        if (rd_acc) begin
            if (rd_word[DATA_W]) begin
                sop_n     = 1'b1;
                err_n     = (state == BODY);
                pkt_rem_n = {1'b0, rd_len} + RW'(1);
                state_n   = BODY;
            end else if (state == BODY) begin
                pkt_rem_n = pkt_rem - RW'(1);
                if (pkt_rem == RW'(1)) begin
                    eop_n   = 1'b1;
                    state_n = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !soft_rst) begin
            mem[wr_ptr] <= {lfd_state, din};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            pkt_rem    <= '0;
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            sop_out    <= 1'b0;
            eop_out    <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            pkt_err    <= 1'b0;
        end else if (soft_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            pkt_rem    <= '0;
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            sop_out    <= 1'b0;
            eop_out    <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= rd_word[DATA_W-1:0];
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            pkt_rem    <= pkt_rem_n;
            state      <= state_n;
            dout_valid <= rd_acc;
            sop_out    <= sop_n;
            eop_out    <= eop_n;
            overflow   <= overflow  | (wr_en & full);
            underflow  <= underflow | (rd_en & empty);
            pkt_err    <= pkt_err   | err_n;
        end
    end

endmodule

// File: tb/tb_pkt_fifo_param.sv
// tb/tb_pkt_fifo_param.sv - directed self-checking bench for pkt_fifo_param (8x16 and 16x64 instances)
module tb_pkt_fifo_param;

    logic        clk = 1'b0;
    logic        rst;

    logic        soft_rst, wr_en, rd_en, lfd_state;
    logic [7:0]  din;
    logic        full, empty, almost_full, almost_empty;
    logic [4:0]  level;
    logic [7:0]  dout;
    logic        dout_valid, sop_out, eop_out, overflow, underflow, pkt_err;

    logic        b_soft_rst, b_wr_en, b_rd_en, b_lfd_state;
    logic [15:0] b_din;
    logic        b_full, b_empty, b_almost_full, b_almost_empty;
    logic [6:0]  b_level;
    logic [15:0] b_dout;
    logic        b_dout_valid, b_sop_out, b_eop_out, b_overflow, b_underflow, b_pkt_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pkt_fifo_param dut_a (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .wr_en(wr_en), .rd_en(rd_en),
        .lfd_state(lfd_state), .din(din), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .dout(dout), .dout_valid(dout_valid), .sop_out(sop_out), .eop_out(eop_out),
        .overflow(overflow), .underflow(underflow), .pkt_err(pkt_err)
    );

    pkt_fifo_param #(.DATA_W(16), .DEPTH(64)) dut_b (
        .clk(clk), .rst(rst), .soft_rst(b_soft_rst), .wr_en(b_wr_en), .rd_en(b_rd_en),
        .lfd_state(b_lfd_state), .din(b_din), .full(b_full), .empty(b_empty),
        .almost_full(b_almost_full), .almost_empty(b_almost_empty), .level(b_level),
        .dout(b_dout), .dout_valid(b_dout_valid), .sop_out(b_sop_out), .eop_out(b_eop_out),
        .overflow(b_overflow), .underflow(b_underflow), .pkt_err(b_pkt_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        wr_en = 1'b1; din = d; lfd_state = lfd;
        tick();
        wr_en = 1'b0; lfd_state = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] d, input logic sop, input logic eop);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, ".valid"}, dout_valid, 1);
        chk({tag, ".dout"}, dout, d);
        chk({tag, ".sop"}, sop_out, sop);
        chk({tag, ".eop"}, eop_out, eop);
    endtask

    task automatic b_wr(input logic [15:0] d, input logic lfd);
        b_wr_en = 1'b1; b_din = d; b_lfd_state = lfd;
        tick();
        b_wr_en = 1'b0; b_lfd_state = 1'b0;
    endtask

    task automatic b_rd_chk(input string tag, input logic [15:0] d, input logic sop, input logic eop);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        chk({tag, ".valid"}, b_dout_valid, 1);
        chk({tag, ".dout"}, b_dout, d);
        chk({tag, ".sop"}, b_sop_out, sop);
        chk({tag, ".eop"}, b_eop_out, eop);
    endtask

    initial begin
        rst = 1'b0;
        soft_rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; lfd_state = 1'b0; din = '0;
        b_soft_rst = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_lfd_state = 1'b0; b_din = '0;
        tick();
        tick();
        rst = 1'b1;
        chk("init.empty", empty, 1);
        chk("init.level", level, 0);

        // 1: async reset in the middle of traffic
        for (int i = 0; i < 6; i++) wr(8'h21 + 8'(i), 1'b0);
        rd_chk("t1.pre", 8'h21, 0, 0);
        chk("t1.pre.level", level, 5);
        rst = 1'b0;
        #1;
        chk("t1.level", level, 0);
        chk("t1.empty", empty, 1);
        chk("t1.aempty", almost_empty, 1);
        chk("t1.full", full, 0);
        chk("t1.afull", almost_full, 0);
        chk("t1.dout", dout, 0);
        chk("t1.valid", dout_valid, 0);
        chk("t1.flags", {sop_out, eop_out, overflow, underflow, pkt_err}, 0);
        tick();
        rst = 1'b1;

        // 2: one packet, hdr len=3 -> 5 words
        wr(8'h0C, 1'b1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h44, 1'b0);
        chk("t2.level", level, 5);
        rd_chk("t2.w1", 8'h0C, 1, 0);
        rd_chk("t2.w2", 8'h11, 0, 0);
        rd_chk("t2.w3", 8'h22, 0, 0);
        rd_chk("t2.w4", 8'h33, 0, 0);
        rd_chk("t2.w5", 8'h44, 0, 1);
        tick();
        chk("t2.idle.valid", dout_valid, 0);
        chk("t2.idle.dout", dout, 8'h44);
        chk("t2.empty", empty, 1);

        // 3: fill to full, overflow attempt, drain
        for (int i = 0; i < 16; i++) begin
            wr(8'h10 + 8'(i), 1'b0);
            chk("t3.fill.level", level, 32'(i + 1));
            chk("t3.fill.afull", almost_full, 32'(i + 1 >= 14));
            chk("t3.fill.aempty", almost_empty, 32'(i + 1 <= 2));
        end
        chk("t3.full", full, 1);
        wr(8'hAA, 1'b0);
        chk("t3.ovf", overflow, 1);
        chk("t3.ovf.level", level, 16);
        for (int i = 0; i < 16; i++) rd_chk("t3.drain", 8'h10 + 8'(i), 0, 0);
        chk("t3.empty", empty, 1);
        chk("t3.ovf.sticky", overflow, 1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("t3.ovf.clr", overflow, 0);

        // 4: level 8, simultaneous read/write across pointer wrap
        for (int i = 0; i < 8; i++) wr(8'h50 + 8'(i), 1'b0);
        for (int k = 0; k < 10; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 8'h58 + 8'(k);
            tick();
            chk("t4.dout", dout, 32'(8'h50 + 8'(k)));
            chk("t4.valid", dout_valid, 1);
            chk("t4.level", level, 8);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int k = 0; k < 8; k++) rd_chk("t4.drain", 8'h5A + 8'(k), 0, 0);
        chk("t4.empty", empty, 1);

        // 5: underflow then soft reset
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t5.udf", underflow, 1);
        chk("t5.valid", dout_valid, 0);
        chk("t5.dout", dout, 8'h61);
        chk("t5.level", level, 0);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("t5.udf.clr", underflow, 0);
        chk("t5.dout.clr", dout, 0);

        // 6: truncated packet, reload, then zero-length header
        wr(8'h0C, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'h04, 1'b1);
        wr(8'hB1, 1'b0);
        wr(8'hB2, 1'b0);
        wr(8'h03, 1'b1);
        wr(8'h77, 1'b0);
        rd_chk("t6.h1", 8'h0C, 1, 0);
        rd_chk("t6.a1", 8'hA1, 0, 0);
        rd_chk("t6.a2", 8'hA2, 0, 0);
        chk("t6.err.pre", pkt_err, 0);
        rd_chk("t6.h2", 8'h04, 1, 0);
        chk("t6.err", pkt_err, 1);
        rd_chk("t6.b1", 8'hB1, 0, 0);
        rd_chk("t6.b2", 8'hB2, 0, 1);
        rd_chk("t6.h0", 8'h03, 1, 0);
        rd_chk("t6.z", 8'h77, 0, 1);
        chk("t6.err.sticky", pkt_err, 1);

        // 6b: same packet check on the 16x64 instance, then thresholds
        b_wr(16'h000C, 1'b1);
        b_wr(16'hA001, 1'b0);
        b_wr(16'hA002, 1'b0);
        b_wr(16'h0004, 1'b1);
        b_wr(16'hB001, 1'b0);
        b_wr(16'hB002, 1'b0);
        b_rd_chk("t6b.h1", 16'h000C, 1, 0);
        b_rd_chk("t6b.a1", 16'hA001, 0, 0);
        b_rd_chk("t6b.a2", 16'hA002, 0, 0);
        chk("t6b.err.pre", b_pkt_err, 0);
        b_rd_chk("t6b.h2", 16'h0004, 1, 0);
        chk("t6b.err", b_pkt_err, 1);
        b_rd_chk("t6b.b1", 16'hB001, 0, 0);
        b_rd_chk("t6b.b2", 16'hB002, 0, 1);
        chk("t6b.empty", b_empty, 1);
        for (int i = 0; i < 62; i++) begin
            b_wr(16'h1000 + 16'(i), 1'b0);
            if (i + 1 == 2)  chk("t6b.ae2", b_almost_empty, 1);
            if (i + 1 == 3)  chk("t6b.ae3", b_almost_empty, 0);
            if (i + 1 == 61) chk("t6b.af61", b_almost_full, 0);
            if (i + 1 == 62) chk("t6b.af62", b_almost_full, 1);
        end
        chk("t6b.level", b_level, 62);
        chk("t6b.full", b_full, 0);
        b_rd_chk("t6b.first", 16'h1000, 0, 0);
        chk("t6b.af61r", b_almost_full, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
